// File: rtl/sc_seq_pkg.sv
// Shared definitions for the stochastic-computing stream sequencer:
// default widths, controller states, seed fix-up value and the LFSR tap set
// of the attached datapath.
package sc_seq_pkg;

    localparam int SC_LEN_W  = 8;
    localparam int SC_LFSR_W = 8;

    // An all-zero seed would lock the LFSR, so it is replaced by this value.
    localparam logic [7:0] SEED_FIX = 8'h01;

    // Feedback taps of the datapath LFSR (bits 6, 5, 2, 0).
    localparam logic [7:0] LFSR_TAPS = 8'b0110_0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Next state of the datapath LFSR: shift left, parity of tapped bits in.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Sample counter and ones accumulator for one bitstream job. The terminal
// flag marks the sample that completes a stream of len_i samples.
module sc_ones_counter
    import sc_seq_pkg::*;
#(
    parameter int LEN_W = SC_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             bit_i,
    input  logic [LEN_W:0]   len_i,
    output logic [LEN_W:0]   ones_o,
    output logic [LEN_W:0]   ones_next_o,
    output logic             last_o
);

    localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};

    logic [LEN_W:0] cnt_q;
    logic [LEN_W:0] ones_q;
    logic [LEN_W:0] ones_d;

    assign ones_d      = ones_q + {{LEN_W{1'b0}}, bit_i};
    assign ones_o      = ones_q;
    assign ones_next_o = ones_d;
    // len_i is never zero while sampling, so len_i - 1 cannot underflow here.
    assign last_o      = (cnt_q == (len_i - ONE));

    // Clear on job acceptance, otherwise advance once per enabled sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            ones_q <= '0;
        end else if (enable_i) begin
            cnt_q  <= cnt_q + ONE;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/sc_stream_sequencer.sv
// Job controller for one stochastic-computing stage. It seeds the stage LFSR,
// clears the delay state, runs the datapath for len cycles while counting the
// ones in the bitstream, and reports the count through a start/done handshake.
module sc_stream_sequencer
    import sc_seq_pkg::*;
#(
    parameter int LEN_W  = SC_LEN_W,
    parameter int LFSR_W = SC_LFSR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LFSR_W-1:0] seed,
    input  logic [LFSR_W-1:0] operand,
    input  logic [LEN_W:0]    len,
    output logic              busy,
    output logic              done,
    output logic [LEN_W:0]    result,
    output logic [LFSR_W-1:0] dp_s_in,
    output logic [LFSR_W-1:0] dp_b,
    output logic              dp_x1_in,
    output logic              dp_x2_in,
    output logic              dp_en,
    input  logic [LFSR_W-1:0] dp_s_out,
    input  logic              dp_x1_out,
    input  logic              dp_x2_out,
    input  logic              dp_bit
);

    seq_state_e        state_q;
    logic [LFSR_W-1:0] operand_q;
    logic [LFSR_W-1:0] seed_q;
    logic [LEN_W:0]    len_q;
    logic              first_q;
    logic              zero_len_q;
    logic [LFSR_W-1:0] s_hold_q;
    logic              x1_hold_q;
    logic              x2_hold_q;
    logic              done_q;
    logic              busy_q;
    logic              dp_en_q;
    logic [LEN_W:0]    result_q;

    logic [LFSR_W-1:0] s_run_d;
    logic              x1_run_d;
    logic              x2_run_d;
    logic              accept;
    logic              sampling;
    logic [LEN_W:0]    ones_cur;
    logic [LEN_W:0]    ones_final;
    logic              last_sample;

    assign accept   = (state_q == IDLE) && start;
    assign sampling = (state_q == RUN);

    // Values presented to the datapath while running: the job seed and
    // cleared delay bits on the first cycle, then the datapath's own
    // registered state fed straight back.
    assign s_run_d  = first_q ? seed_q : dp_s_out;
    assign x1_run_d = first_q ? 1'b0   : dp_x1_out;
    assign x2_run_d = first_q ? 1'b0   : dp_x2_out;

    // Outside RUN the datapath inputs freeze at the last driven values.
    assign dp_s_in  = sampling ? s_run_d  : s_hold_q;
    assign dp_x1_in = sampling ? x1_run_d : x1_hold_q;
    assign dp_x2_in = sampling ? x2_run_d : x2_hold_q;
    assign dp_b     = operand_q;
    assign dp_en    = dp_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

    sc_ones_counter #(
        .LEN_W(LEN_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (accept),
        .enable_i   (sampling),
        .bit_i      (dp_bit),
        .len_i      (len_q),
        .ones_o     (ones_cur),
        .ones_next_o(ones_final),
        .last_o     (last_sample)
    );

    // Controller FSM with registered handshake and datapath-enable outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            operand_q  <= '0;
            seed_q     <= '0;
            len_q      <= '0;
            first_q    <= 1'b0;
            zero_len_q <= 1'b0;
            s_hold_q   <= '0;
            x1_hold_q  <= 1'b0;
            x2_hold_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            dp_en_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        operand_q <= operand;
                        len_q     <= len;
                        seed_q    <= (seed == '0) ? LFSR_W'(SEED_FIX) : seed;
                        busy_q    <= 1'b1;
                        if (len == '0) begin
                            // Empty job: no datapath activity; done is raised
                            // on the following edge so it trails the accept
                            // edge by one cycle.
                            state_q    <= DONE;
                            zero_len_q <= 1'b1;
                            first_q    <= 1'b0;
                            result_q   <= '0;
                        end else begin
                            state_q <= RUN;
                            first_q <= 1'b1;
                            dp_en_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    s_hold_q  <= s_run_d;
                    x1_hold_q <= x1_run_d;
                    x2_hold_q <= x2_run_d;
                    first_q   <= 1'b0;
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        dp_en_q <= 1'b0;
                    end else if (last_sample) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        dp_en_q  <= 1'b0;
                        result_q <= ones_final;
                    end
                end
                DONE: begin
                    if (zero_len_q) begin
                        zero_len_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dp_en_q <= 1'b0;
                end
            endcase
        end
    end

    // The running ones count is only consumed through ones_final.
    logic unused_ones;
    assign unused_ones = ^ones_cur;

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Scoreboard bench for sc_stream_sequencer with a behavioural datapath
// (taps 6,5,2,0) and a selectable bitstream source.
module tb_sc_stream_sequencer;
    import sc_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] operand = 8'h00;
    logic [8:0] len = 9'd0;
    logic       busy, done, dp_x1_in, dp_x2_in, dp_en;
    logic [8:0] result;
    logic [7:0] dp_s_in, dp_b;
    logic [7:0] dp_s_out;
    logic       dp_x1_out, dp_x2_out, dp_bit;

    sc_stream_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed(seed), .operand(operand), .len(len),
        .busy(busy), .done(done), .result(result),
        .dp_s_in(dp_s_in), .dp_b(dp_b), .dp_x1_in(dp_x1_in), .dp_x2_in(dp_x2_in),
        .dp_en(dp_en), .dp_s_out(dp_s_out), .dp_x1_out(dp_x1_out),
        .dp_x2_out(dp_x2_out), .dp_bit(dp_bit)
    );

    always #5 clk = ~clk;

    // Behavioural datapath registers.
    logic [7:0] m_s = 8'h00;
    logic       m_x1 = 1'b0, m_x2 = 1'b0;
    always @(posedge clk) begin
        if (dp_en) begin
            m_s  <= lfsr_next(dp_s_in);
            m_x1 <= dp_bit;
            m_x2 <= dp_x1_in;
        end
    end
    assign dp_s_out  = m_s;
    assign dp_x1_out = m_x1;
    assign dp_x2_out = m_x2;

    // Bitstream source: 0 = all zeros, 1 = all ones, 2 = 1,0,1,0... per job.
    logic [1:0] mode = 2'd0;
    logic       alt = 1'b1;
    always @(posedge clk) alt <= dp_en ? ~alt : 1'b1;
    assign dp_bit = (mode == 2'd1) || ((mode == 2'd2) && alt);

    int cyc = 0;
    int busy_cyc = 0;
    int en_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (busy)  busy_cyc++;
        if (dp_en) en_cyc++;
    end

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [8:0]  res;
        logic [31:0] cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    // Monitor: every done pulse pops one expected job and compares it.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending job", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("done: cycle=%0d result=%0d (expected cycle=%0d result=%0d)",
                         cyc, result, mon_e.cyc, mon_e.res);
                chk("done_result", 32'(result), 32'(mon_e.res));
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic start_job(input logic [7:0] sd, input logic [7:0] op, input logic [8:0] ln,
                             input logic [1:0] md, input bit expect_done,
                             input logic [8:0] res, output int c0);
        exp_t e;
        @(negedge clk);
        mode = md; seed = sd; operand = op; len = ln; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        $display("start: cycle=%0d seed=0x%0h operand=0x%0h len=%0d mode=%0d", c0, sd, op, ln, md);
        if (expect_done) begin
            e.res = res;
            e.cyc = 32'(c0 + ((ln == 9'd0) ? 1 : int'(ln)));
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_within_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int b0;
        int e0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_dp_en", 32'(dp_en), 32'd0);
        chk("rst_dp_s_in", 32'(dp_s_in), 32'd0);
        chk("rst_dp_b", 32'(dp_b), 32'd0);
        chk("rst_dp_x1_in", 32'(dp_x1_in), 32'd0);
        chk("rst_dp_x2_in", 32'(dp_x2_in), 32'd0);
        rst_n = 1'b1;

        // Full-length stream of ones: 256, no wrap, busy for 257 cycles
        b0 = busy_cyc;
        start_job(8'h5A, 8'h80, 9'd256, 2'd1, 1'b1, 9'd256, c0);
        wait_drain(400);
        chk("busy_cycles_len256", 32'(busy_cyc - b0), 32'd257);

        // Alternating stream starting with 1, and an all-zero stream
        start_job(8'hC3, 8'h40, 9'd9, 2'd2, 1'b1, 9'd5, c0);
        wait_drain(40);
        start_job(8'h77, 8'h10, 9'd200, 2'd0, 1'b1, 9'd0, c0);
        wait_drain(300);

        // Zero seed is fixed up; feedback loop closes after the first cycle
        start_job(8'h00, 8'h33, 9'd4, 2'd1, 1'b1, 9'd4, c0);
        chk("seed_c1_dp_en", 32'(dp_en), 32'd1);
        chk("seed_c1_dp_s_in", 32'(dp_s_in), 32'h01);
        chk("seed_c1_dp_x1_in", 32'(dp_x1_in), 32'd0);
        chk("seed_c1_dp_x2_in", 32'(dp_x2_in), 32'd0);
        chk("seed_c1_dp_b", 32'(dp_b), 32'h33);
        @(posedge clk); #1;
        chk("seed_c2_dp_s_in", 32'(dp_s_in), 32'h03);
        chk("seed_c2_s_in_eq_s_out", 32'(dp_s_in), 32'(dp_s_out));
        chk("seed_c2_dp_x1_in", 32'(dp_x1_in), 32'd1);
        chk("seed_c2_dp_x2_in", 32'(dp_x2_in), 32'd0);
        @(posedge clk); #1;
        chk("seed_c3_dp_s_in", 32'(dp_s_in), 32'h07);
        chk("seed_c3_dp_x2_in", 32'(dp_x2_in), 32'd1);
        wait_drain(20);
        chk("hold_dp_s_in", 32'(dp_s_in), 32'h0E);
        chk("hold_dp_en", 32'(dp_en), 32'd0);

        // Zero-length job: done one cycle after accept, no datapath enable
        e0 = en_cyc;
        start_job(8'h11, 8'h22, 9'd0, 2'd1, 1'b1, 9'd0, c0);
        wait_drain(10);
        chk("len0_no_dp_en", 32'(en_cyc - e0), 32'd0);

        // start during RUN and during DONE is ignored
        start_job(8'h21, 8'h05, 9'd20, 2'd1, 1'b1, 9'd20, c0);
        repeat (4) @(negedge clk);
        len = 9'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && cyc != c0 + 20; i++) @(negedge clk);
        chk("probe_in_done_cycle", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_done_ignored", 32'(busy), 32'd0);

        // Establish a prior result of 37, then abort mid-run
        start_job(8'h9D, 8'h01, 9'd37, 2'd1, 1'b1, 9'd37, c0);
        wait_drain(60);
        start_job(8'h42, 8'h24, 9'd100, 2'd1, 1'b0, 9'd0, c0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dp_en", 32'(dp_en), 32'd0);
        chk("abort_result", 32'(result), 32'd37);
        repeat (110) @(posedge clk);
        #1;
        chk("abort_result_later", 32'(result), 32'd37);

        // Abort on the final sample wins over completion
        start_job(8'h42, 8'h24, 9'd5, 2'd1, 1'b0, 9'd0, c0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_last_done", 32'(done), 32'd0);
        chk("abort_last_busy", 32'(busy), 32'd0);
        chk("abort_last_result", 32'(result), 32'd37);
        repeat (5) @(posedge clk);

        // Asynchronous reset mid-run, then a full job afterwards
        start_job(8'h5A, 8'h66, 9'd50, 2'd1, 1'b0, 9'd0, c0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dp_en", 32'(dp_en), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_dp_s_in", 32'(dp_s_in), 32'd0);
        chk("arst_dp_b", 32'(dp_b), 32'd0);
        chk("arst_dp_x1_in", 32'(dp_x1_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_job(8'hE1, 8'h90, 9'd9, 2'd2, 1'b1, 9'd5, c0);
        wait_drain(40);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_stream_sequencer.md
Name: sc_stream_sequencer

Overview:
Job controller for one 8-bit stochastic-computing stage: LFSR-driven comparator SNG, two delay-state bits, and a bitstream output bit. It seeds the stage's LFSR, clears its delay state, and runs it for a programmable stream length. It counts the ones in the output bitstream and returns the count as the binary result. It sits between a host start/done handshake and one datapath instance.

Parameters:
LEN_W, 8, log2 of maximum stream length; max length 2^LEN_W = 256
LFSR_W, 8, width of datapath LFSR state and comparator operand

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; sampled only in IDLE
abort  in  1  cancel running job
seed  in  LFSR_W  LFSR seed for the job
operand  in  LFSR_W  comparator binary operand for the job
len  in  LEN_W+1  stream length in cycles, 0..2^LEN_W
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse, result valid
result  out  LEN_W+1  ones count of last completed job
dp_s_in  out  LFSR_W  to datapath LFSR input
dp_b  out  LFSR_W  to datapath comparator operand
dp_x1_in  out  1  to datapath delay-state input 1
dp_x2_in  out  1  to datapath delay-state input 2
dp_en  out  1  datapath register advance enable
dp_s_out  in  LFSR_W  registered next LFSR state from datapath
dp_x1_out  in  1  registered delay-state 1 from datapath
dp_x2_out  in  1  registered delay-state 2 from datapath
dp_bit  in  1  combinational bitstream output of datapath

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, dp_en=0, dp_x1_in=dp_x2_in=0, dp_s_in=0, dp_b=0, counters=0, first flag=0.
- States: IDLE, RUN, DONE.
- IDLE and start=1 at edge E0: latch operand and len. Latch seed, replacing 0x00 with 0x01 to avoid LFSR lock-up. Set first=1, cnt=0, ones=0. Go to RUN. If len=0, go directly to DONE with result=0.
- RUN:
  - dp_en=1; dp_b=latched operand.
  - First cycle: dp_s_in=latched seed, dp_x1_in=dp_x2_in=0.
  - Later cycles: dp_s_in=dp_s_out, dp_x1_in=dp_x1_out, dp_x2_in=dp_x2_out (feedback loop closed through the controller).
  - Every RUN cycle samples dp_bit: ones += dp_bit, cnt += 1; first cleared after the first cycle.
  - When cnt==len-1 at a sampling edge, go to DONE; result <= ones + dp_bit.
  - Exactly len samples per job.
- DONE: single cycle. done=1, busy=1, dp_en=0, then IDLE. done is high in the cycle beginning at edge E0+len (E0+1 for len=0).
- abort=1 in RUN: next state IDLE, no done, result unchanged, dp_en=0. Abort takes priority over completion on the same edge. abort in IDLE/DONE is ignored.
- start outside IDLE is ignored, including during DONE. No queuing.
- Outside RUN, dp_en=0 and dp_s_in/dp_x*_in hold their last values. Datapath state is don't-care until the next job's first cycle.
- result holds until the next completed job. ones/result width LEN_W+1, so len=256 with all ones gives 256 with no wrap.
- Async reset mid-job returns to IDLE immediately, with no done pulse.

Decomposition:
- Package sc_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - LFSR_W, LEN_W defaults
  - SEED_FIX = 8'h01
  - LFSR taps constant (6,5,2,0) for bench reference model
- One sub-module: sc_ones_counter. It holds the sample counter and ones accumulator, with clear, enable, bit in, count out, and terminal flag.

Test Plan:
- dp_bit tied 1, len=256, seed=0x5A: done exactly 256 cycles after start edge, result=256, busy high 257 cycles.
- dp_bit alternating 1/0 starting 1, len=9: result=5. dp_bit tied 0, len=200: result=0.
- seed=0x00: first RUN cycle dp_s_in=0x01, dp_x1_in=dp_x2_in=0; second cycle dp_s_in equals dp_s_out (behavioural datapath model, taps 6,5,2,0).
- len=0: done one cycle after start, result=0, dp_en never asserted. start pulsed during RUN and DONE: ignored, one done per accepted job.
- abort at RUN cycle 10 of len=100 after prior result=37: no done, result stays 37, IDLE next cycle. Abort coincident with final sample: no done.
- rst_n low mid-RUN: outputs immediately at reset values without waiting for clk edge. New start after release runs a full job correctly.
